// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer and its neighbours.
package fetch_sequencer_pkg;

  localparam int P_WIDTH       = 8;
  localparam int I_WIDTH       = 16;
  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_RUN,
    FS_HALT
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer and its controller/decoder side.
interface fetch_sequencer_if
  import fetch_sequencer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
);

  logic               start;
  logic               stall;
  logic               branch_taken;
  logic [P_WIDTH-1:0] branch_target;
  logic               halt;
  logic [P_WIDTH-1:0] pc;
  logic               fetch_valid;
  logic               done;
  logic               pc_wrap;
  logic [CNT_W-1:0]   retired;

  modport master (
    output start, stall, branch_taken, branch_target, halt,
    input  pc, fetch_valid, done, pc_wrap, retired
  );

  modport slave (
    input  start, stall, branch_taken, branch_target, halt,
    output pc, fetch_valid, done, pc_wrap, retired
  );

endinterface

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count up on inc, stop at all-ones; clear and reset both return to zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && !(&q)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller: start -> run -> halt, with
// branch/stall handling, a sticky wrap flag and a retired-instruction count.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [P_WIDTH-1:0] START_ADDR = '0,
  parameter int                 CNT_W      = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  fetch_sequencer_if.slave bus
);

  fetch_state_t       state, state_nxt;
  logic [P_WIDTH-1:0] pc_q, pc_nxt;
  logic               wrap_q, wrap_nxt;
  logic               cnt_clr, cnt_inc;
  logic [CNT_W-1:0]   cnt_q;

  // State, PC and wrap flag registers; reset discards any run in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FS_IDLE;
      pc_q   <= '0;
      wrap_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc_q   <= pc_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  // Next-state and next-PC selection: stall > halt > branch > increment.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    wrap_nxt  = wrap_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state)
      FS_IDLE, FS_HALT: begin
        if (bus.start) begin
          state_nxt = FS_RUN;
          pc_nxt    = START_ADDR;
          wrap_nxt  = 1'b0;
          cnt_clr   = 1'b1;
        end
      end
      FS_RUN: begin
        if (bus.stall) begin
          // Instruction not retired; decoder inputs are ignored.
        end else if (bus.halt) begin
          state_nxt = FS_HALT;
          cnt_inc   = 1'b1;
        end else if (bus.branch_taken) begin
          pc_nxt  = bus.branch_target;
          cnt_inc = 1'b1;
        end else begin
          pc_nxt  = pc_q + P_WIDTH'(1);
          cnt_inc = 1'b1;
          if (&pc_q) begin
            wrap_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = FS_IDLE;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_retired (
    .clk (clk),
    .rst (reset),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .q   (cnt_q)
  );

  assign bus.pc          = pc_q;
  assign bus.pc_wrap     = wrap_q;
  assign bus.retired     = cnt_q;
  assign bus.fetch_valid = (state == FS_RUN);
  assign bus.done        = (state == FS_HALT);

endmodule
